// File: rtl/led_pkg.sv
// Shared types and frame constants for the LED frame arbiter.
package led_pkg;

  typedef enum logic [2:0] {IDLE, START, PIXEL, END, GAP} state_e;

  localparam int START_BITS     = 32;
  localparam int END_BITS       = 64;
  localparam int BITS_PER_PIXEL = 32;
  localparam int BIT_CNT_W      = $clog2(END_BITS);

  // Round-robin pick between two requesters; last = 1 means requester 1 won last.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

endpackage

// File: rtl/led_bit_serializer.sv
// 32-bit load/shift register plus the two-phase bit clock for the LED strip.
module led_bit_serializer
  import led_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      en,
  input  logic                      load,
  input  logic [BITS_PER_PIXEL-1:0] load_data,
  output logic                      led_clk,
  output logic                      led_data
);

  logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
  logic                      phase_q, phase_d;

  always_comb begin
    shift_d = shift_q;
    phase_d = phase_q;
    if (clear) begin
      shift_d = '0;
      phase_d = 1'b0;
    end else if (en) begin
      phase_d = ~phase_q;
      // The word advances only when leaving phase 1, so data is stable across led_clk rise.
      if (phase_q) shift_d = load ? load_data : {shift_q[BITS_PER_PIXEL-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      phase_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      phase_q <= phase_d;
    end
  end

  assign led_clk  = phase_q;
  assign led_data = shift_q[BITS_PER_PIXEL-1];

endmodule

// File: rtl/led_frame_arbiter.sv
// Two-requester round-robin arbiter that streams one frame at a time to a serial LED strip.
module led_frame_arbiter
  import led_pkg::*;
#(
  parameter int NUM_PIXELS = 64,
  parameter int GAP_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  output logic [1:0]  grant,
  output logic        pix_rd,
  output logic [5:0]  pix_idx,
  input  logic [31:0] pix_data0,
  input  logic [31:0] pix_data1,
  output logic        led_clk,
  output logic        led_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [BIT_CNT_W-1:0] WORD_LAST = BIT_CNT_W'(BITS_PER_PIXEL - 1);
  localparam logic [BIT_CNT_W-1:0] END_LAST  = BIT_CNT_W'(END_BITS - 1);
  localparam logic [5:0]           PIX_LAST  = 6'(NUM_PIXELS - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 pix_rd_q, pix_rd_d;
  logic [5:0]           pix_idx_q, pix_idx_d;
  logic                 frame_done_q, frame_done_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

  logic ser_phase;
  logic ser_clear;
  logic ser_en;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    busy_d       = busy_q;
    pix_rd_d     = 1'b0;
    pix_idx_d    = pix_idx_q;
    frame_done_d = 1'b0;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_d   = rr_pick(req, last_q);
          last_d    = grant_d[1];
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          pix_idx_d = '0;
          state_d   = START;
        end
      end

      START, PIXEL: begin
        if (!ser_phase) begin
          // Entering the last bit's phase 1: fetch the next word if one remains.
          if (bit_cnt_q == WORD_LAST && (state_q == START || pix_idx_q != PIX_LAST)) begin
            pix_rd_d = 1'b1;
            if (state_q == PIXEL) pix_idx_d = pix_idx_q + 6'd1;
          end
        end else if (bit_cnt_q == WORD_LAST) begin
          bit_cnt_d = '0;
          state_d   = pix_rd_q ? PIXEL : END;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      END: begin
        if (ser_phase) begin
          if (bit_cnt_q == END_LAST) begin
            state_d      = GAP;
            frame_done_d = 1'b1;
            grant_d      = 2'b00;
            pix_idx_d    = '0;
            bit_cnt_d    = '0;
            gap_cnt_d    = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_q       <= 1'b1;
      busy_q       <= 1'b0;
      pix_rd_q     <= 1'b0;
      pix_idx_q    <= '0;
      frame_done_q <= 1'b0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      pix_rd_q     <= pix_rd_d;
      pix_idx_q    <= pix_idx_d;
      frame_done_q <= frame_done_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Line is forced quiet whenever the next state is outside the frame.
  assign ser_clear = (state_d == IDLE) || (state_d == GAP);
  assign ser_en    = (state_q == START) || (state_q == PIXEL) || (state_q == END);

  led_bit_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .clear     (ser_clear),
    .en        (ser_en),
    .load      (pix_rd_q),
    .load_data (grant_q[1] ? pix_data1 : pix_data0),
    .led_clk   (ser_phase),
    .led_data  (led_data)
  );

  assign led_clk    = ser_phase;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign pix_rd     = pix_rd_q;
  assign pix_idx    = pix_idx_q;
  assign frame_done = frame_done_q;

endmodule
